// File: rtl/fp_div_seq_if.sv
// Handshake bundle for the sequential single-precision divider.
interface fp_div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        valid;
  logic [31:0] z;
  logic [7:0]  status;

  modport master (output start, a, b, input ready, valid, z, status);
  modport slave  (input start, a, b, output ready, valid, z, status);
endinterface

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider: one restoring quotient bit per
// clock, flush-to-zero on denormal inputs, selectable rounding mode.
package fp_div_pkg;
  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_values;
endpackage

module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter round_values round = IEEE_near
) (
  input logic         clk,
  input logic         rst,
  fp_div_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP, DIV, RND, DONE} state_t;

  state_t             state_r;
  logic [31:0]        a_r, b_r;
  logic               sign_r;
  logic signed [9:0]  e_r;
  logic [24:0]        rem_r;
  logic [23:0]        div_r;
  logic [26:0]        q_r;
  logic [4:0]         cnt_r;
  logic               ready_r, valid_r;
  logic [31:0]        z_r;
  logic [7:0]         status_r;

  // operand classification (denormals count as zero)
  logic               sgn_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic               sp_hit_s;
  logic [31:0]        sp_z_s;
  logic [7:0]         sp_st_s;
  logic signed [9:0]  e_init_s;

  assign sgn_s    = a_r[31] ^ b_r[31];
  assign a_zero_s = (a_r[30:23] == 8'd0);
  assign b_zero_s = (b_r[30:23] == 8'd0);
  assign a_inf_s  = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf_s  = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
  assign a_nan_s  = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan_s  = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
  assign e_init_s = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd127;

  // special-operand result selection, priority NaN > inf > div-by-zero > zero
  always_comb begin
    sp_hit_s = 1'b1;
    sp_z_s   = 32'h0000_0000;
    sp_st_s  = 8'h00;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      sp_z_s  = 32'h7FC0_0000;
      sp_st_s = 8'h04;
    end else if (a_inf_s) begin
      sp_z_s  = {sgn_s, 8'hFF, 23'd0};
      sp_st_s = 8'h02;
    end else if (b_zero_s) begin
      sp_z_s  = {sgn_s, 8'hFF, 23'd0};
      sp_st_s = 8'h42;
    end else if (a_zero_s || b_inf_s) begin
      sp_z_s  = {sgn_s, 31'd0};
      sp_st_s = 8'h01;
    end else begin
      sp_hit_s = 1'b0;
    end
  end

  // one restoring step: subtract when the partial remainder covers the divisor
  logic        qbit_s;
  logic [23:0] diff_s;
  logic [24:0] rem_nx_s;

  always_comb begin
    qbit_s   = (rem_r >= {1'b0, div_r});
    diff_s   = rem_r[23:0] - div_r;
    if (qbit_s) begin
      rem_nx_s = {diff_s, 1'b0};
    end else begin
      rem_nx_s = {rem_r[23:0], 1'b0};
    end
  end

  // normalisation, rounding and range checks on the finished quotient
  logic [25:0]        qn_s;
  logic signed [9:0]  en_s, er_s;
  logic               g_s, rb_s, st_s, inex_s, inc_s, carry_s;
  logic [22:0]        mant_s;
  logic [31:0]        rn_z_s;
  logic [7:0]         rn_st_s;

  always_comb begin
    if (q_r[26]) begin
      qn_s = q_r[25:0];
      en_s = e_r;
    end else begin
      qn_s = {q_r[24:0], 1'b0};
      en_s = e_r - 10'sd1;
    end
    g_s    = qn_s[2];
    rb_s   = qn_s[1];
    st_s   = qn_s[0] | (rem_r != 25'd0);
    inex_s = g_s | rb_s | st_s;
    case (round)
      IEEE_near: inc_s = g_s & (rb_s | st_s | qn_s[3]);
      IEEE_zero: inc_s = 1'b0;
      IEEE_pinf: inc_s = ~sign_r & inex_s;
      IEEE_ninf: inc_s = sign_r & inex_s;
      near_up:   inc_s = g_s & (rb_s | st_s | ~sign_r);
      away_zero: inc_s = inex_s;
      default:   inc_s = 1'b0;
    endcase
    mant_s  = qn_s[25:3] + {22'd0, inc_s};
    carry_s = inc_s & (&qn_s[25:3]);
    er_s    = en_s + $signed({9'd0, carry_s});
    rn_z_s  = {sign_r, er_s[7:0], mant_s};
    rn_st_s = {2'b00, inex_s, 5'd0};
    if (er_s > 10'sd254) begin
      case (round)
        IEEE_zero: rn_z_s = {sign_r, 31'h7F7F_FFFF};
        IEEE_pinf: rn_z_s = sign_r ? {1'b1, 31'h7F7F_FFFF} : 32'h7F80_0000;
        IEEE_ninf: rn_z_s = sign_r ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        default:   rn_z_s = {sign_r, 8'hFF, 23'd0};
      endcase
      rn_st_s = (rn_z_s[30:0] == 31'h7F80_0000) ? 8'h32 : 8'h30;
    end else if (er_s < 10'sd1) begin
      rn_z_s  = {sign_r, 31'd0};
      rn_st_s = 8'h29;
    end else begin
      rn_z_s  = {sign_r, er_s[7:0], mant_s};
      rn_st_s = {2'b00, inex_s, 5'd0};
    end
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      sign_r   <= 1'b0;
      e_r      <= 10'sd0;
      rem_r    <= 25'd0;
      div_r    <= 24'd0;
      q_r      <= 27'd0;
      cnt_r    <= 5'd0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      z_r      <= 32'd0;
      status_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            ready_r <= 1'b0;
            state_r <= PREP;
          end
        end
        PREP: begin
          if (sp_hit_s) begin
            z_r      <= sp_z_s;
            status_r <= sp_st_s;
            valid_r  <= 1'b1;
            state_r  <= DONE;
          end else begin
            sign_r  <= sgn_s;
            e_r     <= e_init_s;
            rem_r   <= {2'b01, a_r[22:0]};
            div_r   <= {1'b1, b_r[22:0]};
            q_r     <= 27'd0;
            cnt_r   <= 5'd26;
            state_r <= DIV;
          end
        end
        DIV: begin
          q_r   <= {q_r[25:0], qbit_s};
          rem_r <= rem_nx_s;
          if (cnt_r == 5'd0) begin
            state_r <= RND;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        RND: begin
          z_r      <= rn_z_s;
          status_r <= rn_st_s;
          valid_r  <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.valid  = valid_r;
  assign bus.z      = z_r;
  assign bus.status = status_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench: six dividers (one per rounding mode) share stimulus; a
// monitor checks results, latency, ready and reset behaviour.
module tb_fp_div_seq;
  import fp_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        drv_start = 1'b0;
  logic [31:0] drv_a = 32'd0;
  logic [31:0] drv_b = 32'd0;
  int unsigned cyc = 0;

  logic [5:0]       ready_v, valid_v;
  logic [5:0][31:0] z_v;
  logic [5:0][7:0]  st_v;

  always #5 clk = ~clk;

  // cycle counter: value after edge N is N
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < 6; i++) begin : g_dut
    fp_div_seq_if ifc ();
    fp_div_seq #(.round(round_values'(i))) dut (.clk(clk), .rst(rst), .bus(ifc));
    assign ifc.start  = drv_start;
    assign ifc.a      = drv_a;
    assign ifc.b      = drv_b;
    assign ready_v[i] = ifc.ready;
    assign valid_v[i] = ifc.valid;
    assign z_v[i]     = ifc.z;
    assign st_v[i]    = ifc.status;
  end

  typedef struct packed {
    logic [5:0][31:0] z;
    logic [5:0][7:0]  st;
    int unsigned      t0;
    int unsigned      lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference quotient from the arithmetic definition: exact integer division
  // of the significands, then the stated rounding and range rules.
  function automatic logic [40:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input round_values md);
    logic s, az, bz, ai, bi, an, bn, g, rb, sk, inex, inc;
    int ea, eb, e;
    longint unsigned num, den, q, r, m;
    logic [31:0] maxf, inf;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);   bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    inf  = {s, 8'hFF, 23'd0};
    maxf = {s, 31'h7F7F_FFFF};
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 32'h7FC0_0000, 8'h04};
    if (ai) return {1'b1, inf, 8'h02};
    if (bz) return {1'b1, inf, 8'h42};
    if (az || bi) return {1'b1, s, 31'd0, 8'h01};
    num = (64'(a[22:0]) + 64'h80_0000) << 26;
    den = 64'(b[22:0]) + 64'h80_0000;
    q = num / den;
    r = num % den;
    e = ea - eb + 127;
    if (q < 64'h400_0000) begin
      q = q * 2;
      e = e - 1;
    end
    g = q[2]; rb = q[1]; sk = q[0] | (r != 0);
    inex = g | rb | sk;
    m = q >> 3;
    case (md)
      IEEE_near: inc = g & (rb | sk | m[0]);
      IEEE_pinf: inc = ~s & inex;
      IEEE_ninf: inc = s & inex;
      near_up:   inc = g & (rb | sk | ~s);
      away_zero: inc = inex;
      default:   inc = 1'b0;
    endcase
    m = m + 64'(inc);
    if (m >= 64'h100_0000) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e > 254) begin
      case (md)
        IEEE_zero: return {1'b0, maxf, 8'h30};
        IEEE_pinf: return s ? {1'b0, maxf, 8'h30} : {1'b0, inf, 8'h32};
        IEEE_ninf: return s ? {1'b0, inf, 8'h32} : {1'b0, maxf, 8'h30};
        default:   return {1'b0, inf, 8'h32};
      endcase
    end
    if (e < 1) return {1'b0, s, 31'd0, 8'h29};
    return {1'b0, s, 8'(e), m[22:0], 2'b00, inex, 5'd0};
  endfunction

  function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned t0);
    exp_t e;
    logic [40:0] r;
    e.t0 = t0;
    e.lat = 29;
    for (int i = 0; i < 6; i++) begin
      r = ref_div(a, b, round_values'(i));
      e.z[i]  = r[39:8];
      e.st[i] = r[7:0];
      e.lat   = r[40] ? 1 : 29;
    end
    return e;
  endfunction

  // monitor: reset outputs, ready profile, result and latency against scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic exp_ready;
    if (rst) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("reset_out_m%0d", i), 64'({ready_v[i], valid_v[i], z_v[i], st_v[i]}),
              64'({1'b1, 1'b0, 32'd0, 8'd0}));
      exp_q.delete();
    end else begin
      exp_ready = 1'b1;
      if (exp_q.size() > 0)
        if (cyc >= exp_q[0].t0 && cyc <= exp_q[0].t0 + exp_q[0].lat) exp_ready = 1'b0;
      check("ready", 64'(ready_v), 64'({6{exp_ready}}));
      if (valid_v != 6'h00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(valid_v), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("valid_cycle", 64'(cyc - e.t0), 64'(e.lat));
          check("valid_all", 64'(valid_v), 64'h3F);
          for (int i = 0; i < 6; i++) begin
            check($sformatf("z_m%0d", i), 64'(z_v[i]), 64'(e.z[i]));
            check($sformatf("status_m%0d", i), 64'(st_v[i]), 64'(e.st[i]));
          end
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].t0 + exp_q[0].lat) begin
        check("valid_missing", 64'(valid_v), 64'h3F);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (ready_v != 6'h3F) begin
      @(posedge clk); #1;
      w++;
      if (w > 100) begin
        $display("FAIL ready_wait: ready=%b expected 111111", ready_v);
        $fatal(1, "ready never returned");
      end
    end
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, output int unsigned t0);
    wait_ready();
    drv_a = ia; drv_b = ib; drv_start = 1'b1;
    t0 = cyc + 1;
    exp_q.push_back(make_exp(ia, ib, t0));
    @(posedge clk); #1;
    drv_start = 1'b0;
  endtask

  // start held high across two operations; operands change while busy
  task automatic issue_held(input logic [31:0] a1, input logic [31:0] b1,
                            input logic [31:0] a2, input logic [31:0] b2);
    exp_t e1;
    int unsigned t2;
    int w = 0;
    wait_ready();
    drv_a = a1; drv_b = b1; drv_start = 1'b1;
    e1 = make_exp(a1, b1, cyc + 1);
    exp_q.push_back(e1);
    t2 = e1.t0 + e1.lat + 2;
    @(posedge clk); #1;
    drv_a = a2; drv_b = b2;
    exp_q.push_back(make_exp(a2, b2, t2));
    while (cyc != t2 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    drv_start = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] sp [6];
    int sel;
    sp[0] = 32'h0000_0000; sp[1] = 32'h8000_0000; sp[2] = 32'h7F80_0000;
    sp[3] = 32'hFF80_0000; sp[4] = 32'h7FC0_0001; sp[5] = 32'h0040_0000;
    sel = $urandom_range(0, 9);
    if (sel == 0) return sp[$urandom_range(0, 5)];
    if (sel <= 3) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  int unsigned t0;
  logic [31:0] dir_a [8];
  logic [31:0] dir_b [8];

  initial begin
    dir_a[0] = 32'h40C0_0000; dir_b[0] = 32'h4000_0000;
    dir_a[1] = 32'h3F80_0000; dir_b[1] = 32'h4040_0000;
    dir_a[2] = 32'h3F80_0000; dir_b[2] = 32'h0000_0000;
    dir_a[3] = 32'h0000_0000; dir_b[3] = 32'h0000_0000;
    dir_a[4] = 32'h7F00_0000; dir_b[4] = 32'h3E80_0000;
    dir_a[5] = 32'h0080_0000; dir_b[5] = 32'h4000_0000;
    dir_a[6] = 32'h0040_0000; dir_b[6] = 32'h3F80_0000;
    dir_a[7] = 32'hBF80_0000; dir_b[7] = 32'h4040_0000;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) issue(dir_a[k], dir_b[k], t0);
    // abort a division in its cycle 15
    issue(32'h40C0_0000, 32'h4000_0000, t0);
    while (cyc < t0 + 14) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(32'h40C0_0000, 32'h4000_0000, t0);
    issue_held(32'h3F80_0000, 32'h4040_0000, 32'h4120_0000, 32'hC0E0_0000);
    issue_held(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000);
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 9) issue_held(rand_fp(), rand_fp(), rand_fp(), rand_fp());
      else issue(rand_fp(), rand_fp(), t0);
    end
    begin
      int w = 0;
      while (exp_q.size() > 0 && w < 200) begin
        @(posedge clk);
        w++;
      end
      if (exp_q.size() > 0) begin
        $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        $fatal(1, "results never arrived");
      end
    end
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Iterative IEEE-754 single-precision divider, the inverse-operation companion to the registered floating-point multiplier in the arithmetic datapath. It accepts an operand pair through a start/ready handshake and computes z = a / b with one restoring-division quotient bit per clock. It applies the same rounding-mode parameter and the same 8-bit status-flag format as the multiplier, and returns the result with a one-cycle valid pulse. Its area is small in exchange for multi-cycle latency.

## Interface
- round, default IEEE_near: rounding mode of type round_values; one of IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- a  in  32  dividend (IEEE-754 single).
- b  in  32  divisor (IEEE-754 single).
- ready  out  1  high only in IDLE.
- valid  out  1  one-cycle pulse; z and status are valid in this cycle.
- z  out  32  quotient; holds until the next result.
- status  out  8  flags: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [6] div_by_zero, [7] reserved 0.

## Operation
- States: IDLE, PREP, DIV, RND, DONE.
- IDLE: ready=1. When start=1, latch a and b, then go to PREP. start is ignored in every other state.
- PREP: classify operands. Denormal inputs are treated as signed zero (flush-to-zero, as in the multiplier).
- Special cases in PREP load z and status directly, then go to DONE:
  - either operand NaN, 0/0, or inf/inf: z=0x7FC00000, status[2]=1.
  - finite nonzero / 0: z = signed inf, status[1]=1, status[6]=1.
  - inf / finite: z = signed inf, status[1]=1.
  - 0 / nonzero, or finite / inf: z = signed zero, status[0]=1.
- Normal case in PREP:
  - sign = sa^sb.
  - 10-bit signed exponent e = ea - eb + 127.
  - Remainder = {1,ma}, divisor = {1,mb}.
  - Counter = 26, then go to DIV.
- DIV: one restoring step per cycle, producing 27 quotient bits q[26:0], MSB first. The counter decrements each cycle. Leave DIV after the step with counter=0.
- RND: one cycle.
  - If q[26]=0: shift q left by 1 and decrement e.
  - Mantissa = q[25:3]. Guard = q[2]. Round = q[1]. Sticky = q[0] OR (remainder != 0).
  - Inexact = guard|round|sticky.
  - Increment rule:
    - IEEE_near: ties-to-even.
    - near_up: half rounds toward +inf.
    - IEEE_zero: truncate.
    - IEEE_pinf / IEEE_ninf: directed rounding by sign.
    - away_zero: increment if inexact.
  - Mantissa carry-out increments e.
- Overflow (e > 254 after rounding): status[4]=1, status[5]=1.
  - IEEE_zero: z = ±0x7F7FFFFF.
  - IEEE_pinf: +inf for positive results, -max finite for negative.
  - IEEE_ninf: the mirror of IEEE_pinf.
  - All other modes: ±inf.
  - status[1] is set when z is inf.
- Underflow (e < 1 after rounding): z = signed zero; status[3], status[5] and status[0] set.
- Otherwise: z = {sign, e[7:0], mantissa}; status[5] = inexact; status[0] = 0.
- DONE: valid=1, ready=0, then go to IDLE.

## Timing
- Reset (async, at any time, including mid-division): state=IDLE, ready=1, valid=0, z=0, status=0, all internal registers cleared. No valid pulse follows for an aborted operation.
- Count the accepting edge (start=1, ready=1) as cycle 0.
- Normal operands: PREP in cycle 1, DIV in cycles 2–28, RND in cycle 29, valid in cycle 30. The next start is accepted in cycle 31 (ready=1).
- Special operands: PREP in cycle 1, valid in cycle 2.
- z and status update only on the edge into DONE and are stable from then until the next such edge.
- Back-to-back requests: start held high is accepted in the first IDLE cycle after DONE. Throughput is 1 per 31 cycles (normal) or 1 per 3 cycles (special).

## Test plan
- a=0x40C00000, b=0x40000000, IEEE_near -> z=0x40400000, status=0x00, valid exactly in cycle 30, ready low in cycles 1–30.
- a=0x3F800000, b=0x40400000 -> IEEE_near z=0x3EAAAAAB; IEEE_zero z=0x3EAAAAAA; status=0x20 in both.
- a=0x3F800000, b=0x00000000 -> z=0x7F800000, status=0x42, valid in cycle 2. a=0, b=0 -> z=0x7FC00000, status=0x04.
- a=0x7F000000, b=0x3E800000 -> IEEE_near z=0x7F800000, status=0x32; IEEE_zero z=0x7F7FFFFF, status=0x30.
- a=0x00800000, b=0x40000000 -> z=0x00000000, status=0x29. a=0x00400000 (denormal), b=0x3F800000 -> z=0, status=0x01.
- Assert rst in cycle 15 of a division -> all outputs 0 and ready=1 immediately. No valid pulse follows. A fresh 6.0/2.0 then completes correctly.
